// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between the core's instruction-fetch (IF)
//   port and its load/store data (DM) port. Accesses are serialised one at a
//   time through a four-state FSM (IDLE, ISSUE, WAIT, RESP), and each memory
//   response is routed back to the port that issued the request.
//
// Ports
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   if_request        fetch request, held until if_valid
//   if_address        fetch word address
//   if_data_out       fetched word, updated only when if_valid pulses
//   if_valid          one-cycle fetch completion pulse
//   dm_request        data request, held until dm_valid
//   dm_we_re          1 = write, 0 = read
//   dm_mask           byte enables for writes
//   dm_address        data word address
//   dm_data_in        write data
//   dm_data_out       read data, updated only when dm_valid pulses
//   dm_valid          one-cycle data completion pulse (reads and writes)
//   mem_request       one-cycle request pulse to the memory
//   mem_we_re, mem_mask, mem_address, mem_data_in
//                     registered copy of the granted command
//   mem_data_out      memory read data
//   mem_valid         memory completion pulse
//   busy              high whenever the FSM is not in IDLE
//
// Configuration
//   ARB_ROUND_ROBIN_EN  when defined, ties alternate between the ports using a
//                       last-served bit; otherwise DM always wins a tie.

module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_request,
  input  logic [ADDR_WIDTH-1:0] if_address,
  output logic [DATA_WIDTH-1:0] if_data_out,
  output logic                  if_valid,
  input  logic                  dm_request,
  input  logic                  dm_we_re,
  input  logic [3:0]            dm_mask,
  input  logic [ADDR_WIDTH-1:0] dm_address,
  input  logic [DATA_WIDTH-1:0] dm_data_in,
  output logic [DATA_WIDTH-1:0] dm_data_out,
  output logic                  dm_valid,
  output logic                  mem_request,
  output logic                  mem_we_re,
  output logic [3:0]            mem_mask,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                r_state;
  logic                  r_owner;
  logic                  r_memRequest;
  logic                  r_memWeRe;
  logic [3:0]            r_memMask;
  logic [ADDR_WIDTH-1:0] r_memAddress;
  logic [DATA_WIDTH-1:0] r_memDataIn;
  logic [DATA_WIDTH-1:0] r_ifDataOut;
  logic [DATA_WIDTH-1:0] r_dmDataOut;
  logic                  r_ifValid;
  logic                  r_dmValid;
  logic                  r_busy;

  logic                  w_anyRequest;
  logic                  w_grantDm;

  assign w_anyRequest = if_request | dm_request;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers which port won the previous grant so a tie goes to the other
  // one. Starts at DM so the first tie after reset is given to IF.
  logic r_lastServed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lastServed <= 1'b1;
    end else if (r_state == IDLE && w_anyRequest) begin
      r_lastServed <= w_grantDm;
    end
  end

  assign w_grantDm = dm_request & (~if_request | ~r_lastServed);
`else
  // Fixed priority: any DM request beats a simultaneous IF request.
  assign w_grantDm = dm_request;
`endif

  // Arbiter FSM. Requests are only sampled in IDLE; the granted command is
  // captured into the mem_* registers and held until the next grant. The
  // response data goes straight into the owner's data register on the cycle
  // mem_valid arrives, so RESP only has to present the valid pulse. A
  // response in the same cycle as the request skips WAIT entirely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_memRequest <= 1'b0;
      r_memWeRe    <= 1'b0;
      r_memMask    <= 4'b0000;
      r_memAddress <= '0;
      r_memDataIn  <= '0;
      r_ifDataOut  <= '0;
      r_dmDataOut  <= '0;
      r_ifValid    <= 1'b0;
      r_dmValid    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_memRequest <= 1'b0;
      r_ifValid    <= 1'b0;
      r_dmValid    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyRequest) begin
            r_state      <= ISSUE;
            r_owner      <= w_grantDm;
            r_memRequest <= 1'b1;
            r_busy       <= 1'b1;
            if (w_grantDm) begin
              r_memWeRe    <= dm_we_re;
              r_memMask    <= dm_mask;
              r_memAddress <= dm_address;
              r_memDataIn  <= dm_data_in;
            end else begin
              r_memWeRe    <= 1'b0;
              r_memMask    <= 4'b1111;
              r_memAddress <= if_address;
              r_memDataIn  <= '0;
            end
          end
        end
        ISSUE, WAIT: begin
          if (mem_valid) begin
            r_state <= RESP;
            if (r_owner) begin
              r_dmDataOut <= mem_data_out;
              r_dmValid   <= 1'b1;
            end else begin
              r_ifDataOut <= mem_data_out;
              r_ifValid   <= 1'b1;
            end
          end else begin
            r_state <= WAIT;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_request = r_memRequest;
  assign mem_we_re   = r_memWeRe;
  assign mem_mask    = r_memMask;
  assign mem_address = r_memAddress;
  assign mem_data_in = r_memDataIn;
  assign if_data_out = r_ifDataOut;
  assign if_valid    = r_ifValid;
  assign dm_data_out = r_dmDataOut;
  assign dm_valid    = r_dmValid;
  assign busy        = r_busy;

endmodule
